// File: rtl/mcs4.sv
// Shared MCS-4 bus types and instruction-decode helpers.
package mcs4;

    typedef logic [3:0] char_t;

    typedef enum logic [2:0] {
        A1, A2, A3, M1, M2, X1, X2, X3
    } instr_cyc_t;

    localparam char_t OPR_IO = 4'hE;

    // True for the first word of JCN, FIM, JUN, JMS and ISZ.
    function automatic logic is_two_word(input char_t opr, input char_t opa);
        logic r;
        case (opr)
            4'h1, 4'h4, 4'h5, 4'h7: r = 1'b1;
            4'h2:                   r = ~opa[0];
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/i4004_fetch_if.sv
// MCS-4 bus plus fetch-to-execute handshake seen by the 4004 fetch unit.
interface i4004_fetch_if;

    logic               sync;
    logic               cm_rom;
    mcs4::char_t        dbus_in;
    mcs4::char_t        dbus_out;
    logic               instr_valid;
    mcs4::char_t        instr_opr;
    mcs4::char_t        instr_opa;
    logic               instr_second;
    logic [11:0]        instr_pc;
    logic               jmp_en;
    logic [11:0]        jmp_addr;
    logic               src_en;
    mcs4::char_t        src_data;

    modport master (
        output sync, cm_rom, dbus_out,
        output instr_valid, instr_opr, instr_opa, instr_second, instr_pc,
        input  dbus_in, jmp_en, jmp_addr, src_en, src_data
    );

    modport slave (
        input  sync, cm_rom, dbus_out,
        input  instr_valid, instr_opr, instr_opa, instr_second, instr_pc,
        output dbus_in, jmp_en, jmp_addr, src_en, src_data
    );

endinterface

// File: rtl/i4004_fetch.sv
// 4004 instruction-fetch front end: phase sequencer, program counter,
// address drive in A1-A3 and OPR/OPA capture in M1/M2.
module i4004_fetch #(
    parameter logic [11:0] RESET_PC = 12'h000
) (
    input  logic           clk,
    input  logic           rst,
    i4004_fetch_if.master  bus
);
    import mcs4::*;

    instr_cyc_t  phase_q, phase_d;
    logic [11:0] pc_q, pc_d;
    char_t       opr_q, opa_q;
    logic        second_q;
    logic [11:0] ipc_q;
    logic        isecond_q;

    always_comb begin
        phase_d = instr_cyc_t'(phase_q + 3'd1);
        pc_d    = pc_q;
        if (phase_q == X1) begin
            pc_d = pc_q + 12'd1;
        end
        // A jump in X3 replaces the increment already applied in X1.
        if (phase_q == X3 && bus.jmp_en) begin
            pc_d = bus.jmp_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q   <= X3;
            pc_q      <= RESET_PC;
            opr_q     <= '0;
            opa_q     <= '0;
            second_q  <= 1'b0;
            ipc_q     <= RESET_PC;
            isecond_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            pc_q    <= pc_d;
            case (phase_q)
                M1: begin
                    opr_q     <= bus.dbus_in;
                    ipc_q     <= pc_q;
                    isecond_q <= second_q;
                end
                M2: opa_q <= bus.dbus_in;
                X1: second_q <= is_two_word(opr_q, opa_q) && !second_q;
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.dbus_out = '0;
        case (phase_q)
            A1:      bus.dbus_out = pc_q[3:0];
            A2:      bus.dbus_out = pc_q[7:4];
            A3:      bus.dbus_out = pc_q[11:8];
            X2:      bus.dbus_out = bus.src_en ? bus.src_data : '0;
            default: bus.dbus_out = '0;
        endcase
    end

    assign bus.sync         = (phase_q == X3);
    assign bus.cm_rom       = (phase_q == M2 && opr_q == OPR_IO && !second_q)
                            || (phase_q == X2 && bus.src_en);
    assign bus.instr_valid  = (phase_q == X1);
    assign bus.instr_opr    = opr_q;
    assign bus.instr_opa    = opa_q;
    assign bus.instr_second = isecond_q;
    assign bus.instr_pc     = ipc_q;

endmodule
